pc_gen: RTL and testbench

Parametrised program-counter generator for the RV32I fetch stage. It supplies the next fetch address each cycle over a valid/ready handshake to instruction fetch and applies execute-stage redirects and trap entry with a one-cycle bubble. A small return-address stack (RAS) predicts targets for predecoded call/return instructions. It supersedes the fixed-width, enable-only PC register.

---
 rtl/pc_gen.sv | 137 +++++++++++++
 tb/tb_pc_gen.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// pc_gen: program-counter generator for the RV32I fetch stage.
//
// Supplies the fetch address over a valid/ready handshake, applies
// execute-stage redirects and trap entry with a one-cycle bubble, and
// predicts call/return targets through a small return-address stack.
//
// Ports:
//   clk            clock, rising edge
//   rst            asynchronous active-high reset
//   fetch_ready_i  fetch accepts pc_o this cycle
//   redirect_i     execute-stage redirect request
//   redirect_pc_i  redirect target
//   trap_i         trap entry request
//   call_i         instruction at pc_o is a call (handshake qualified)
//   call_target_i  predecoded call target
//   ret_i          instruction at pc_o is a return (handshake qualified)
//   pc_o           current fetch address
//   pc_valid_o     pc_o valid for fetch
//   misalign_o     one-cycle pulse: misaligned redirect converted to trap
//   ras_count_o    number of valid RAS entries
//
// state  | meaning
// BOOT   | first cycle after reset, no fetch, redirect/trap ignored
// RUN    | pc_o valid, accepts advance the PC
// BUBBLE | one invalid cycle after a redirect or trap
module pc_gen #(
  parameter int unsigned            XLEN      = 32,
  parameter logic [XLEN-1:0]        RESET_VEC = '0,
  parameter logic [XLEN-1:0]        TRAP_VEC  = XLEN'('h100),
  parameter int unsigned            RAS_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         fetch_ready_i,
  input  logic                         redirect_i,
  input  logic [XLEN-1:0]              redirect_pc_i,
  input  logic                         trap_i,
  input  logic                         call_i,
  input  logic [XLEN-1:0]              call_target_i,
  input  logic                         ret_i,
  output logic [XLEN-1:0]              pc_o,
  output logic                         pc_valid_o,
  output logic                         misalign_o,
  output logic [$clog2(RAS_DEPTH):0]   ras_count_o
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);

  typedef enum logic [1:0] {BOOT, RUN, BUBBLE} state_t;

  state_t            state_q, state_n;
  logic [XLEN-1:0]   pc_n;
  logic [XLEN-1:0]   pc_plus4;
  logic              mis_n;
  logic [CW-1:0]     cnt_n;
  logic [PW-1:0]     top_q, top_n;
  logic              push;
  logic              accept;

  logic [XLEN-1:0]   ras_mem [RAS_DEPTH];

  assign pc_plus4 = pc_o + XLEN'(4);
  // pc_valid_o is high exactly in RUN, so it doubles as the RUN qualifier.
  assign accept   = pc_valid_o & fetch_ready_i;

  always_comb begin
    state_n = state_q;
    pc_n    = pc_o;
    mis_n   = 1'b0;
    cnt_n   = ras_count_o;
    top_n   = top_q;
    push    = 1'b0;
    case (state_q)
      BOOT: state_n = RUN;
      default: begin
        if (trap_i) begin
          pc_n    = TRAP_VEC;
          cnt_n   = '0;
          state_n = BUBBLE;
        end else if (redirect_i && (redirect_pc_i[1:0] != 2'b00)) begin
          pc_n    = TRAP_VEC;
          cnt_n   = '0;
          mis_n   = 1'b1;
          state_n = BUBBLE;
        end else if (redirect_i) begin
          pc_n    = redirect_pc_i;
          state_n = BUBBLE;
        end else begin
          state_n = RUN;
          if (accept) begin
            if (call_i) begin
              // Circular buffer: a push when full overwrites the oldest entry.
              push  = 1'b1;
              pc_n  = call_target_i;
              top_n = top_q + PW'(1);
              cnt_n = (ras_count_o == DEPTH_C) ? ras_count_o : ras_count_o + CW'(1);
            end else if (ret_i && (ras_count_o != '0)) begin
              pc_n  = ras_mem[top_q];
              top_n = top_q - PW'(1);
              cnt_n = ras_count_o - CW'(1);
            end else begin
              pc_n = pc_plus4;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= BOOT;
      pc_o        <= RESET_VEC;
      pc_valid_o  <= 1'b0;
      misalign_o  <= 1'b0;
      ras_count_o <= '0;
      top_q       <= '0;
    end else begin
      state_q     <= state_n;
      pc_o        <= pc_n;
      pc_valid_o  <= (state_n == RUN);
      misalign_o  <= mis_n;
      ras_count_o <= cnt_n;
      top_q       <= top_n;
    end
  end

  // RAS contents are don't-care after reset; only the count is meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      ras_mem[top_n] <= pc_plus4;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

  localparam logic [31:0] RESET_VEC = 32'h0;
  localparam logic [31:0] TRAP_VEC  = 32'h100;
  localparam int          DEPTH     = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_ready_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        trap_i;
  logic        call_i;
  logic [31:0] call_target_i;
  logic        ret_i;
  logic [31:0] pc_o;
  logic        pc_valid_o;
  logic        misalign_o;
  logic [2:0]  ras_count_o;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic        m_valid;
  logic        m_boot;
  logic        m_mis;
  logic [31:0] m_ras[$];

  pc_gen #(.XLEN(32), .RESET_VEC(RESET_VEC), .TRAP_VEC(TRAP_VEC), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .fetch_ready_i(fetch_ready_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .trap_i(trap_i),
    .call_i(call_i), .call_target_i(call_target_i),
    .ret_i(ret_i),
    .pc_o(pc_o), .pc_valid_o(pc_valid_o),
    .misalign_o(misalign_o), .ras_count_o(ras_count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc    = RESET_VEC;
    m_valid = 1'b0;
    m_boot  = 1'b1;
    m_mis   = 1'b0;
    m_ras.delete();
  endtask

  // One rising edge of the architectural behaviour, using the inputs currently driven.
  task automatic model_edge();
    logic acc;
    acc   = m_valid && fetch_ready_i;
    m_mis = 1'b0;
    if (m_boot) begin
      m_boot  = 1'b0;
      m_valid = 1'b1;
    end else if (trap_i) begin
      m_pc = TRAP_VEC; m_ras.delete(); m_valid = 1'b0;
    end else if (redirect_i && redirect_pc_i[1:0] != 2'b00) begin
      m_pc = TRAP_VEC; m_ras.delete(); m_valid = 1'b0; m_mis = 1'b1;
    end else if (redirect_i) begin
      m_pc = redirect_pc_i; m_valid = 1'b0;
    end else begin
      m_valid = 1'b1;
      if (acc) begin
        if (call_i) begin
          m_ras.push_back(m_pc + 32'd4);
          if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
          m_pc = call_target_i;
        end else if (ret_i && m_ras.size() > 0) begin
          m_pc = m_ras.pop_back();
        end else begin
          m_pc = m_pc + 32'd4;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("pc", pc_o, m_pc);
    chk("valid", 32'(pc_valid_o), 32'(m_valid));
    chk("misalign", 32'(misalign_o), 32'(m_mis));
    chk("ras_count", 32'(ras_count_o), 32'(m_ras.size()));
  endtask

  // Drive inputs (called just after a falling edge), take one rising edge, check, return at falling edge.
  task automatic step(input logic rdy, input logic rd, input logic [31:0] rpc,
                      input logic tr, input logic cl, input logic [31:0] ct, input logic rt);
    fetch_ready_i = rdy; redirect_i = rd; redirect_pc_i = rpc;
    trap_i = tr; call_i = cl; call_target_i = ct; ret_i = rt;
    @(posedge clk);
    #1;
    model_edge();
    check_all();
    @(negedge clk);
  endtask

  task automatic seq();   step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0); endtask
  task automatic redir(input logic [31:0] a); step(1'b1, 1'b1, a, 1'b0, 1'b0, 32'h0, 1'b0); endtask
  task automatic call(input logic [31:0] t); step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, t, 1'b0); endtask
  task automatic ret();   step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1); endtask

  initial begin
    logic [31:0] rpc, ct;
    rst = 1'b1;
    fetch_ready_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0; trap_i = 1'b0;
    call_i = 1'b0; call_target_i = '0; ret_i = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst = 1'b0;

    // Boot and sequential fetch
    seq();  chk("boot_pc0", pc_o, 32'h0);
    seq();  seq(); chk("seq_pc8", pc_o, 32'h8);

    // Stall
    repeat (3) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("stall_hold", pc_o, 32'h8);
    seq();  chk("stall_release", pc_o, 32'hC);

    // Redirect, then trap with a non-empty RAS
    redir(32'h200); chk("redir_bubble", 32'(pc_valid_o), 32'h0);
    seq();          chk("redir_valid", pc_o, 32'h200);
    call(32'h40);   chk("pre_trap_cnt", 32'(ras_count_o), 32'h1);
    step(1'b1, 1'b1, 32'h200, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("trap_pc", pc_o, 32'h100);
    chk("trap_cnt", 32'(ras_count_o), 32'h0);
    seq();

    // Misaligned redirect
    redir(32'h202); chk("mis_pulse", 32'(misalign_o), 32'h1);
    seq();          chk("mis_clear", 32'(misalign_o), 32'h0);

    // RAS basic
    redir(32'h10); seq();
    call(32'h80);  chk("call_tgt", pc_o, 32'h80);
    seq();         chk("after_call", pc_o, 32'h84);
    ret();         chk("ret_tgt", pc_o, 32'h14);

    // RAS overflow / underflow
    redir(32'h0); seq();
    for (int i = 1; i <= 5; i++) call(32'(i) << 8);
    chk("ras_sat", 32'(ras_count_o), 32'h4);
    ret(); chk("ret1", pc_o, 32'h404);
    ret(); chk("ret2", pc_o, 32'h304);
    ret(); chk("ret3", pc_o, 32'h204);
    ret(); chk("ret4", pc_o, 32'h104);
    ret(); chk("ret_empty", pc_o, 32'h108);

    // Wrap
    redir(32'hFFFF_FFFC); seq();
    seq(); chk("wrap", pc_o, 32'h0);

    // Reset during bubble
    redir(32'h300);
    rst = 1'b1;
    #1;
    model_reset();
    chk("midrst_pc", pc_o, 32'h0);
    chk("midrst_valid", 32'(pc_valid_o), 32'h0);
    check_all();
    rst = 1'b0;

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rpc = $urandom() & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hC);
      if ($urandom_range(0, 3) == 0) rpc = rpc | 32'($urandom_range(0, 3));
      ct = $urandom() & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) ct = 32'hFFFF_FFFC;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 20) == 0, rpc,
           $urandom_range(0, 40) == 0, $urandom_range(0, 5) == 0, ct,
           $urandom_range(0, 4) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
